// File: rtl/lcd_port_if.sv
// LCD port bundle: the LSU-side LCD register word plus every pin-side
// signal driven by lcd_port_driver. The master drives io_lcd (the LSU,
// or the bench); the slave is the driver that produces the pin levels.
interface lcd_port_if;
    logic [31:0] io_lcd;
    logic [7:0]  lcd_data_o;
    logic        lcd_rs_o;
    logic        lcd_rw_o;
    logic        lcd_en_o;
    logic        lcd_on_o;
    logic        lcd_busy_o;
    logic        lcd_ack_o;

    modport master (
        output io_lcd,
        input  lcd_data_o,
        input  lcd_rs_o,
        input  lcd_rw_o,
        input  lcd_en_o,
        input  lcd_on_o,
        input  lcd_busy_o,
        input  lcd_ack_o
    );

    modport slave (
        input  io_lcd,
        output lcd_data_o,
        output lcd_rs_o,
        output lcd_rw_o,
        output lcd_en_o,
        output lcd_on_o,
        output lcd_busy_o,
        output lcd_ack_o
    );
endinterface

// File: rtl/lcd_port_driver.sv
// HD44780-style character LCD bus-cycle timer.
// Software writes one word to io_lcd and toggles REQ (bit 9). This block
// latches RS/DATA, then runs a complete write cycle: address setup, EN
// pulse, hold, and the command execution wait. Clear/home commands get the
// long execution wait. lcd_ack_o toggles once when each cycle completes.
module lcd_port_driver #(
    parameter int SETUP_CYC = 4,
    parameter int PULSE_CYC = 16,
    parameter int HOLD_CYC  = 2,
    parameter int EXEC_CYC  = 2000,
    parameter int LONG_CYC  = 80000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    lcd_port_if.slave  bus
);

    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_HE  = (HOLD_CYC > EXEC_CYC) ? HOLD_CYC : EXEC_CYC;
    localparam int MAX_SPHE = (MAX_SP > MAX_HE) ? MAX_SP : MAX_HE;
    localparam int MAX_CYC = (MAX_SPHE > LONG_CYC) ? MAX_SPHE : LONG_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_WAIT  = 3'd4
    } state_e;

    // Clear display (0x01) and return home (0x02/0x03) need the long wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        is_long_cmd = (rs == 1'b0) && (data >= 8'h01) && (data <= 8'h03);
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_seen_q, req_seen_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             on_q;
    logic             req_pending_s;
    logic             unused_bits_s;

    assign req_pending_s = (bus.io_lcd[9] != req_seen_q);

    // Register bits 30:10 carry nothing for this block.
    assign unused_bits_s = ^bus.io_lcd[30:10];

    // Next-state logic: sequence the write cycle and compute pin levels.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_seen_d = req_seen_q;
        data_d     = data_q;
        rs_d       = rs_q;
        busy_d     = busy_q;
        ack_d      = ack_q;
        en_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_pending_s) begin
                    req_seen_d = bus.io_lcd[9];
                    rs_d       = bus.io_lcd[8];
                    data_d     = bus.io_lcd[7:0];
                    busy_d     = 1'b1;
                    cnt_d      = SETUP_LD;
                    state_d    = ST_SETUP;
                end else begin
                    cnt_d      = CNT_ZERO;
                end
            end
            ST_SETUP: begin
                if (cnt_q == CNT_ZERO) begin
                    cnt_d   = PULSE_LD;
                    state_d = ST_PULSE;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            ST_PULSE: begin
                if (cnt_q == CNT_ZERO) begin
                    cnt_d   = HOLD_LD;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_ZERO) begin
                    cnt_d   = is_long_cmd(rs_q, data_q) ? LONG_LD : EXEC_LD;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_ZERO) begin
                    busy_d  = 1'b0;
                    ack_d   = ~ack_q;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // EN is registered from the next state so it is high exactly while in PULSE.
        if (state_d == ST_PULSE) begin
            en_d = 1'b1;
        end else begin
            en_d = 1'b0;
        end
    end

    // State, counter and pin registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_ZERO;
            req_seen_q <= 1'b0;
            data_q     <= 8'h00;
            rs_q       <= 1'b0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_seen_q <= req_seen_d;
            data_q     <= data_d;
            rs_q       <= rs_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
        end
    end

    // Power/backlight follows register bit 31 every cycle, regardless of the FSM.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            on_q <= 1'b0;
        end else begin
            on_q <= bus.io_lcd[31];
        end
    end

    assign bus.lcd_data_o = data_q;
    assign bus.lcd_rs_o   = rs_q;
    assign bus.lcd_rw_o   = 1'b0;
    assign bus.lcd_en_o   = en_q;
    assign bus.lcd_on_o   = on_q;
    assign bus.lcd_busy_o = busy_q;
    assign bus.lcd_ack_o  = ack_q;

endmodule
